// File: rtl/div_pkg.sv
// Shared types and constants for the sequential radix-2 divider and its
// EXECUTE-stage users (FS opcodes sit next to the ALU's MUL/MUI codes).
package div_pkg;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  localparam int WIDTH_DEF = 32;

  localparam logic [4:0] FS_DIV = 5'b11100;
  localparam logic [4:0] FS_DVI = 5'b11101;

  localparam int CNT_W_DEF = $clog2(WIDTH_DEF + 1);

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem,quo} left, trial-subtract the
// divisor and keep the difference only when it does not go negative.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0]   rem_sh;
  logic             fits;
  logic [WIDTH-1:0] diff;

  assign rem_sh = {rem, quo[WIDTH-1]};
  assign fits   = rem_sh >= {1'b0, divisor};
  // When fits, the true difference is below divisor, so WIDTH bits suffice.
  assign diff   = rem_sh[WIDTH-1:0] - divisor;

  assign rem_next = fits ? diff : rem_sh[WIDTH-1:0];
  assign quo_next = {quo[WIDTH-2:0], fits};

endmodule

// File: rtl/seq_divider.sv
// Iterative radix-2 restoring divider, WIDTH+1 cycles per normal divide.
// Define DIV_SIGNED_EN to honour signed_op (abs/sign fix-up and V overflow).
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             Z,
  output logic             N,
  output logic             V,
  output logic             div_zero
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state, state_nxt;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] rem_w, quo_w, dvsr_w;
  logic [WIDTH-1:0] rem_nxt, quo_nxt;
  logic [WIDTH-1:0] q_fix, r_fix;
  logic             neg_q, neg_r;
  logic             sgn, a_neg, b_neg, is_zero, is_ovf;

  function automatic logic [WIDTH-1:0] abs_mag(input logic [WIDTH-1:0] x,
                                               input logic neg);
    return neg ? (~x + 1'b1) : x;
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] x,
                                                  input logic neg);
    return neg ? (~x + 1'b1) : x;
  endfunction

`ifdef DIV_SIGNED_EN
  assign sgn = signed_op;
`else
  logic unused_signed_op;
  assign unused_signed_op = signed_op;
  assign sgn = 1'b0;
`endif

  assign a_neg   = sgn & dividend[WIDTH-1];
  assign b_neg   = sgn & divisor[WIDTH-1];
  assign is_zero = (divisor == '0);
  assign is_ovf  = sgn && (dividend == MOST_NEG) && (&divisor);

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_w),
    .quo      (quo_w),
    .divisor  (dvsr_w),
    .rem_next (rem_nxt),
    .quo_next (quo_nxt)
  );

  assign q_fix = apply_sign(quo_w, neg_q);
  assign r_fix = apply_sign(rem_w, neg_r);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && !is_zero && !is_ovf) state_nxt = CALC;
      CALC:    if (count == LAST) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control and architected outputs: reset clears them, aborting any divide.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      Z         <= 1'b0;
      N         <= 1'b0;
      V         <= 1'b0;
      div_zero  <= 1'b0;
      count     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          Z        <= 1'b0;
          N        <= 1'b0;
          V        <= 1'b0;
          div_zero <= 1'b0;
          count    <= '0;
          if (is_zero) begin
            quotient  <= '1;
            remainder <= dividend;
            div_zero  <= 1'b1;
            N         <= 1'b1;
            done      <= 1'b1;
          end else if (is_ovf) begin
            quotient  <= MOST_NEG;
            remainder <= '0;
            V         <= 1'b1;
            N         <= 1'b1;
            done      <= 1'b1;
          end else begin
            busy <= 1'b1;
          end
        end
        CALC: count <= count + 1'b1;
        FIX: begin
          quotient  <= q_fix;
          remainder <= r_fix;
          Z         <= (q_fix == '0);
          N         <= q_fix[WIDTH-1];
          busy      <= 1'b0;
          done      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Working registers carry data only and need no reset.
  always_ff @(posedge clk) begin
    case (state)
      IDLE: if (start) begin
        rem_w  <= '0;
        quo_w  <= abs_mag(dividend, a_neg);
        dvsr_w <= abs_mag(divisor, b_neg);
        neg_q  <= a_neg ^ b_neg;
        neg_r  <= a_neg;
      end
      CALC: begin
        rem_w <= rem_nxt;
        quo_w <= quo_nxt;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: latency, results, flags and control sequencing.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst, start, signed_op;
  logic [31:0] dividend, divisor;
  logic        busy, done, Z, N, V, div_zero;
  logic [31:0] quotient, remainder;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  seq_divider #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .signed_op (signed_op),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .Z         (Z),
    .N         (N),
    .V         (V),
    .div_zero  (div_zero)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // After the accepting edge, count edges until done and cycles with busy high.
  task automatic wait_done(input string tag, output int lat, output int busy_cnt);
    lat = 0;
    busy_cnt = 0;
    while (!done && lat < 80) begin
      if (busy) busy_cnt++;
      tick();
      lat++;
    end
    if (!done) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input logic sop, input logic [31:0] eq, input logic [31:0] er,
                     input logic ez, input logic en, input logic ev, input logic edz,
                     input int elat);
    int lat, bcnt;
    dividend  = a;
    divisor   = b;
    signed_op = sop;
    start     = 1'b1;
    tick();
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    wait_done(tag, lat, bcnt);
    check({tag, "_lat"}, lat, elat);
    check({tag, "_busycyc"}, bcnt, elat);
    check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    check({tag, "_q"}, quotient, eq);
    check({tag, "_r"}, remainder, er);
    check({tag, "_flags"}, {28'd0, Z, N, V, div_zero}, {28'd0, ez, en, ev, edz});
  endtask

  initial begin
    int lat, bcnt, dcnt;
    rst = 1'b1; start = 1'b0; signed_op = 1'b0; dividend = '0; divisor = '0;
    tick();
    tick();
    check("rst_outs", {busy, done, Z, N, V, div_zero}, 32'd0);
    check("rst_q", quotient, 32'd0);
    check("rst_r", remainder, 32'd0);
    rst = 1'b0;
    tick();

    run("u100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 1'b0, 1'b0, 1'b0, 33);
    tick();
    check("done_pulse", {31'd0, done}, 32'd0);
    check("hold_q", quotient, 32'd14);

`ifdef DIV_SIGNED_EN
    run("s-100_7", 32'hFFFF_FF9C, 32'd7, 1'b1, 32'hFFFF_FFF2, 32'hFFFF_FFFE,
        1'b0, 1'b1, 1'b0, 1'b0, 33);
`else
    run("s-100_7", 32'hFFFF_FF9C, 32'd7, 1'b1, 32'h2492_4916, 32'd2,
        1'b0, 1'b0, 1'b0, 1'b0, 33);
`endif

    run("div0", 32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd5, 1'b0, 1'b1, 1'b0, 1'b1, 0);

`ifdef DIV_SIGNED_EN
    run("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0,
        1'b0, 1'b1, 1'b1, 1'b0, 0);
`else
    run("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'h8000_0000,
        1'b1, 1'b0, 1'b0, 1'b0, 33);
`endif
    tick();

    // Second start at k+5 must be ignored.
    dividend = 32'd1000; divisor = 32'd10; signed_op = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    dividend = 32'd77; divisor = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("ign", lat, bcnt);
    check("ign_lat", lat + 5, 33);
    check("ign_q", quotient, 32'd100);
    check("ign_r", remainder, 32'd0);
    tick();

    // Reset at k+10 aborts the divide.
    dividend = 32'd50; divisor = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_ctl", {busy, done, Z, N, V, div_zero}, 32'd0);
    check("abort_q", quotient, 32'd0);
    check("abort_r", remainder, 32'd0);
    dcnt = 0;
    repeat (40) begin
      if (done) dcnt++;
      tick();
    end
    check("abort_nodone", dcnt, 0);

    run("u3_5", 32'd3, 32'd5, 1'b0, 32'd0, 32'd3, 1'b1, 1'b0, 1'b0, 1'b0, 33);
    // Start in the done cycle: back-to-back accept.
    run("b2b", 32'd200, 32'd9, 1'b0, 32'd22, 32'd2, 1'b0, 1'b0, 1'b0, 1'b0, 33);
    run("b2b_div0", 32'hDEAD_BEEF, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'hDEAD_BEEF,
        1'b0, 1'b1, 1'b0, 1'b1, 0);
    run("u_big", 32'hFFFF_FFFF, 32'h0001_0000, 1'b0, 32'h0000_FFFF, 32'h0000_FFFF,
        1'b0, 1'b0, 1'b0, 1'b0, 33);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
